// File: rtl/mult_div_if.sv
// E-stage multiply/divide bus: forwarded operands and op select in, stall
// handshake and HI/LO read data out.
interface mult_div_if;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic [2:0]  MDOp_E;
  logic        RdSel_E;
  logic        Start_E;
  logic        Busy_E;
  logic [31:0] MDdata_E;

  modport master (
    output A_E, B_E, MDOp_E, RdSel_E,
    input  Start_E, Busy_E, MDdata_E
  );

  modport slave (
    input  A_E, B_E, MDOp_E, RdSel_E,
    output Start_E, Busy_E, MDdata_E
  );
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Results are computed at issue,
// held in temp registers, and committed after a fixed busy window.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  md
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [31:0] hi_reg, lo_reg;
  logic [31:0] hi_tmp_reg, lo_tmp_reg;
  logic [31:0] count_reg;
  logic        busy_reg;
  logic        wb_en_reg;

  logic        start;
  logic        is_div;
  logic        div_zero;
  logic [31:0] divisor;
  logic [63:0] s_prod, u_prod;
  logic signed [31:0] s_quot, s_rem;
  logic [63:0] result_next;
  logic [31:0] cycles_next;

  assign start    = (md.MDOp_E >= OP_MULT) && (md.MDOp_E <= OP_DIVU) && !busy_reg;
  assign is_div   = (md.MDOp_E == OP_DIV) || (md.MDOp_E == OP_DIVU);
  assign div_zero = (md.B_E == 32'd0);

  // Dividing by 1 in the overflow case yields exactly the MIPS answer
  // (quotient 0x80000000, remainder 0) and keeps the zero case defined.
  assign divisor = (div_zero ||
                    (md.MDOp_E == OP_DIV && md.A_E == 32'h8000_0000 && md.B_E == 32'hFFFF_FFFF))
                   ? 32'd1 : md.B_E;

  assign s_prod = $unsigned($signed({{32{md.A_E[31]}}, md.A_E}) *
                            $signed({{32{md.B_E[31]}}, md.B_E}));
  assign u_prod = {32'd0, md.A_E} * {32'd0, md.B_E};
  assign s_quot = $signed(md.A_E) / $signed(divisor);
  assign s_rem  = $signed(md.A_E) % $signed(divisor);

  always_comb begin
    result_next = 64'd0;
    cycles_next = 32'(MULT_CYCLES - 1);
    case (md.MDOp_E)
      OP_MULT:  result_next = s_prod;
      OP_MULTU: result_next = u_prod;
      OP_DIV: begin
        result_next = {$unsigned(s_rem), $unsigned(s_quot)};
        cycles_next = 32'(DIV_CYCLES - 1);
      end
      OP_DIVU: begin
        result_next = {md.A_E % divisor, md.A_E / divisor};
        cycles_next = 32'(DIV_CYCLES - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      hi_tmp_reg <= 32'd0;
      lo_tmp_reg <= 32'd0;
      count_reg  <= 32'd0;
      busy_reg   <= 1'b0;
      wb_en_reg  <= 1'b0;
    end else if (busy_reg) begin
      // Any op presented while busy is dropped; only the countdown advances.
      if (count_reg == 32'd0) begin
        busy_reg <= 1'b0;
        if (wb_en_reg) begin
          hi_reg <= hi_tmp_reg;
          lo_reg <= lo_tmp_reg;
        end
      end else begin
        count_reg <= count_reg - 32'd1;
      end
    end else if (start) begin
      hi_tmp_reg <= result_next[63:32];
      lo_tmp_reg <= result_next[31:0];
      busy_reg   <= 1'b1;
      count_reg  <= cycles_next;
      wb_en_reg  <= !(is_div && div_zero);
    end else if (md.MDOp_E == OP_MTHI) begin
      hi_reg <= md.A_E;
    end else if (md.MDOp_E == OP_MTLO) begin
      lo_reg <= md.A_E;
    end
  end

  assign md.Start_E  = start;
  assign md.Busy_E   = busy_reg;
  assign md.MDdata_E = md.RdSel_E ? hi_reg : lo_reg;
endmodule
